// File: rtl/f1_start_sequencer.sv
// F1 start-light sequencer: trigger detect, lamp fill, random hold, GO pulse.
// Optional reaction timer enabled by defining F1_REACTION_TIMER_EN.
module f1_start_sequencer #(
    parameter int unsigned LIGHTS     = 8,
    parameter int unsigned TICK_DIV   = 16,
    parameter int unsigned LFSR_WIDTH = 7,
    parameter int unsigned TIME_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    output logic [LIGHTS-1:0]     lights,
    output logic                  go,
    output logic                  busy,
    output logic [TIME_WIDTH-1:0] react_time,
    output logic                  react_valid,
    output logic                  false_start
);

    localparam int unsigned PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, FILL, HOLD, GO} state_t;

    state_t                state, state_nxt;
    logic [PW-1:0]         presc;
    logic [LFSR_WIDTH-1:0] lfsr, hold_cnt, hold_cnt_nxt;
    logic                  trigger_q, trig_edge, tick, presc_clr;
    logic [LIGHTS-1:0]     lights_nxt;
    logic                  go_nxt, false_start_nxt;

`ifdef F1_REACTION_TIMER_EN
    logic [TIME_WIDTH-1:0] timer, timer_nxt, react_time_nxt;
    logic                  react_valid_nxt;
`endif

    assign trig_edge = trigger & ~trigger_q;
    assign tick      = (presc == PW'(TICK_DIV - 1));

    always_comb begin
        state_nxt       = state;
        lights_nxt      = lights;
        go_nxt          = 1'b0;
        false_start_nxt = false_start;
        hold_cnt_nxt    = hold_cnt;
        presc_clr       = 1'b0;
`ifdef F1_REACTION_TIMER_EN
        timer_nxt       = timer;
        react_time_nxt  = react_time;
        react_valid_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                lights_nxt = '0;
                if (trig_edge) begin
                    state_nxt       = FILL;
                    lights_nxt      = LIGHTS'(1);
                    false_start_nxt = 1'b0;
                    presc_clr       = 1'b1;
                end
            end
            FILL: begin
                if (trig_edge) begin
                    state_nxt       = IDLE;
                    lights_nxt      = '0;
                    false_start_nxt = 1'b1;
                end else if (tick) begin
                    lights_nxt = {lights[LIGHTS-2:0], 1'b1};
                    // The shift fills the bar exactly when every lower lamp is already lit.
                    if (&lights[LIGHTS-2:0]) begin
                        state_nxt    = HOLD;
                        hold_cnt_nxt = lfsr;
                    end
                end
            end
            HOLD: begin
                if (trig_edge) begin
                    state_nxt       = IDLE;
                    lights_nxt      = '0;
                    false_start_nxt = 1'b1;
                end else if (tick) begin
                    if (hold_cnt == LFSR_WIDTH'(1)) begin
                        state_nxt  = GO;
                        lights_nxt = '0;
                        go_nxt     = 1'b1;
`ifdef F1_REACTION_TIMER_EN
                        timer_nxt  = '0;
`endif
                    end else begin
                        hold_cnt_nxt = hold_cnt - LFSR_WIDTH'(1);
                    end
                end
            end
            GO: begin
`ifdef F1_REACTION_TIMER_EN
                if (timer != '1) timer_nxt = timer + TIME_WIDTH'(1);
                if (trig_edge) begin
                    react_time_nxt  = timer;
                    react_valid_nxt = 1'b1;
                    state_nxt       = IDLE;
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            presc       <= '0;
            lfsr        <= LFSR_WIDTH'(1);
            trigger_q   <= 1'b0;
            hold_cnt    <= '0;
            lights      <= '0;
            go          <= 1'b0;
            busy        <= 1'b0;
            false_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            presc       <= (presc_clr || tick) ? '0 : presc + PW'(1);
            lfsr        <= {lfsr[LFSR_WIDTH-2:0], lfsr[LFSR_WIDTH-1] ^ lfsr[LFSR_WIDTH-2]};
            trigger_q   <= trigger;
            hold_cnt    <= hold_cnt_nxt;
            lights      <= lights_nxt;
            go          <= go_nxt;
            busy        <= (state_nxt != IDLE);
            false_start <= false_start_nxt;
        end
    end

`ifdef F1_REACTION_TIMER_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer       <= '0;
            react_time  <= '0;
            react_valid <= 1'b0;
        end else begin
            timer       <= timer_nxt;
            react_time  <= react_time_nxt;
            react_valid <= react_valid_nxt;
        end
    end
`else
    assign react_time  = '0;
    assign react_valid = 1'b0;
`endif

endmodule

// File: tb/tb_f1_start_sequencer.sv
// Directed bench for f1_start_sequencer; reaction-time steps compiled only with F1_REACTION_TIMER_EN.
module tb_f1_start_sequencer;

    localparam int unsigned LIGHTS = 8;
    localparam int unsigned TD     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trigger = 1'b0;
    logic [7:0]  lights;
    logic        go, busy, react_valid, false_start;
    logic [15:0] react_time;

    int          n_vec = 0;
    int          n_err = 0;
    int          hold_d = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    logic [6:0]  ref_lfsr, ref_prev;

    f1_start_sequencer #(
        .LIGHTS(LIGHTS), .TICK_DIV(TD), .LFSR_WIDTH(7), .TIME_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .lights(lights), .go(go), .busy(busy),
        .react_time(react_time), .react_valid(react_valid), .false_start(false_start)
    );

    always #5 clk = ~clk;

    // Reference generator for x^7+x^6+1; ref_prev holds the value seen by the last edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_lfsr <= 7'd1;
            ref_prev <= 7'd1;
        end else begin
            ref_prev <= ref_lfsr;
            ref_lfsr <= {ref_lfsr[5:0], ref_lfsr[6] ^ ref_lfsr[5]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && react_valid !== 1'b0) begin
            if (exp_q.size() == 0) chk("react_valid_unexpected", 32'(react_valid), 32'd0);
            else begin
                exp_v = exp_q.pop_front();
                chk("react_time", 32'(react_time), 32'(exp_v));
            end
        end
    end

    // Start on the next edge, then check the bar for cycles 0..upto after the start edge.
    task automatic start_fill(input int upto);
        int ones;
        logic [7:0] exp_l;
        @(negedge clk);
        trigger = 1'b1;
        for (int i = 0; i <= upto; i++) begin
            @(negedge clk);
            if (i == 0) begin
                trigger = 1'b0;
                chk("busy_start", 32'(busy), 32'd1);
                chk("false_start_cleared", 32'(false_start), 32'd0);
            end
            ones  = (i / TD + 1 > LIGHTS) ? LIGHTS : i / TD + 1;
            exp_l = 8'((1 << ones) - 1);
            chk($sformatf("fill_lights_c%0d", i), 32'(lights), 32'(exp_l));
            if (i == (LIGHTS - 1) * TD) hold_d = int'(ref_prev);
        end
    endtask

    task automatic hold_go();
        for (int j = 1; j <= 4 * hold_d; j++) begin
            @(negedge clk);
            if (j < 4 * hold_d) chk("hold_lights", 32'(lights), 32'hFF);
            else begin
                chk("go_lights", 32'(lights), 32'h00);
                chk("go_pulse", 32'(go), 32'd1);
            end
            if (j == 4 * hold_d - 1) chk("go_early", 32'(go), 32'd0);
        end
    endtask

`ifdef F1_REACTION_TIMER_EN
    task automatic react(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
        trigger = 1'b1;
        exp_q.push_back(16'(n));
        @(negedge clk);
        chk("react_busy", 32'(busy), 32'd0);
        chk("react_valid_pulse", 32'(react_valid), 32'd1);
        trigger = 1'b0;
        @(negedge clk);
        chk("react_valid_one_cycle", 32'(react_valid), 32'd0);
    endtask
`endif

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_lights", 32'(lights), 32'd0);
        chk("rst_go", 32'(go), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_react_time", 32'(react_time), 32'd0);
        chk("rst_react_valid", 32'(react_valid), 32'd0);
        chk("rst_false_start", 32'(false_start), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        start_fill((LIGHTS - 1) * TD);
        hold_go();
`ifdef F1_REACTION_TIMER_EN
        react(25);
        start_fill((LIGHTS - 1) * TD);
        hold_go();
        react(3);
`else
        @(negedge clk);
        chk("go_one_cycle", 32'(go), 32'd0);
        chk("busy_after_go", 32'(busy), 32'd0);
        chk("react_time_tied", 32'(react_time), 32'd0);
        start_fill((LIGHTS - 1) * TD);
        hold_go();
        @(negedge clk);
        chk("busy_after_go2", 32'(busy), 32'd0);
`endif

        // False start at 0x07 with trigger held high afterwards
        start_fill(2 * TD);
        trigger = 1'b1;
        @(negedge clk);
        chk("fs_flag", 32'(false_start), 32'd1);
        chk("fs_lights", 32'(lights), 32'd0);
        chk("fs_busy", 32'(busy), 32'd0);
`ifdef F1_REACTION_TIMER_EN
        chk("fs_react_time", 32'(react_time), 32'd3);
`else
        chk("fs_react_time", 32'(react_time), 32'd0);
`endif
        repeat (20) @(negedge clk);
        chk("held_no_restart_busy", 32'(busy), 32'd0);
        chk("held_no_restart_lights", 32'(lights), 32'd0);
        chk("fs_sticky", 32'(false_start), 32'd1);
        trigger = 1'b0;
        @(negedge clk);

        // Restart clears the flag; reset lands mid-hold
        start_fill((LIGHTS - 1) * TD + 2);
        rst = 1'b0;
        #1;
        chk("arst_lights", 32'(lights), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_go", 32'(go), 32'd0);
        chk("arst_false_start", 32'(false_start), 32'd0);
        chk("arst_react_valid", 32'(react_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_fill(TD);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
